// File: rtl/fractal_sync_nd_local_rf.sv
// Local synchronization register file for a fractal sync node with N_DIMS
// independent dimensions. Each dimension resolves barrier requests against
// N_REGS_PER_DIM toggle entries and keeps a registered pending count.
// Optional entry expiry is enabled by defining FRACTAL_SYNC_ND_LOCAL_RF_TIMEOUT_EN.
module fractal_sync_nd_local_rf #(
  parameter int unsigned N_DIMS         = 2,
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned N_REGS_PER_DIM = 4,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned TIMEOUT        = 256
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic [N_DIMS-1:0][N_PORTS-1:0][ID_WIDTH-1:0]        id_i,
  input  logic [N_DIMS-1:0][N_PORTS-1:0]                      check_i,
  output logic [N_DIMS-1:0][N_PORTS-1:0]                      present_o,
  output logic [N_DIMS-1:0][N_PORTS-1:0]                      id_err_o,
  output logic [N_DIMS-1:0][N_PORTS-1:0]                      bypass_o,
  output logic [N_DIMS-1:0][N_PORTS-1:0]                      ignore_o,
  input  logic                                                flush_i,
  output logic [N_DIMS-1:0][$clog2(N_REGS_PER_DIM+1)-1:0]     pending_o,
  output logic [N_DIMS-1:0]                                   timeout_o,
  output logic [N_DIMS-1:0][ID_WIDTH-2:0]                     timeout_id_o
);

  localparam int unsigned IDX_W = ID_WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(N_REGS_PER_DIM + 1);

  // Reject parameterisations the index arithmetic cannot support.
  if (N_DIMS < 1 || N_PORTS < 2 || N_REGS_PER_DIM < 1 || ID_WIDTH < 2 ||
      TIMEOUT < 2 || (ID_WIDTH - 1) < $clog2(N_REGS_PER_DIM)) begin : g_param_check
    $error("fractal_sync_nd_local_rf: illegal parameterisation");
  end

  logic [N_DIMS-1:0][N_REGS_PER_DIM-1:0] entry_q;
  logic [N_DIMS-1:0][N_REGS_PER_DIM-1:0] entry_d;
  logic [N_DIMS-1:0][N_REGS_PER_DIM-1:0] toggle;
  logic [N_DIMS-1:0][N_REGS_PER_DIM-1:0] expire;
  logic [N_DIMS-1:0][N_PORTS-1:0]        req_valid;
  logic [N_DIMS-1:0][N_PORTS-1:0]        dup;
  logic [N_DIMS-1:0][N_PORTS-1:0]        lower_dup;
  logic [N_DIMS-1:0][N_PORTS-1:0][IDX_W-1:0] idx;
  logic [N_DIMS-1:0][CNT_W-1:0]          pending_d;
  logic [N_DIMS-1:0][N_PORTS-1:0]        unused_id_lsb;

  // Decode local index and range-check each request.
  always_comb begin
    idx           = '0;
    req_valid     = '0;
    id_err_o      = '0;
    unused_id_lsb = '0;
    for (int unsigned d = 0; d < N_DIMS; d++) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        idx[d][p]           = id_i[d][p][ID_WIDTH-1:1];
        unused_id_lsb[d][p] = id_i[d][p][0];
        req_valid[d][p]     = check_i[d][p] &&
                              ({1'b0, idx[d][p]} < (IDX_W+1)'(N_REGS_PER_DIM));
        id_err_o[d][p]      = check_i[d][p] & ~req_valid[d][p];
      end
    end
  end

  // Find same-cycle requesters sharing an index; lower_dup marks non-leaders.
  always_comb begin
    dup       = '0;
    lower_dup = '0;
    for (int unsigned d = 0; d < N_DIMS; d++) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        for (int unsigned q = 0; q < N_PORTS; q++) begin
          if (q != p && req_valid[d][p] && req_valid[d][q] && idx[d][p] == idx[d][q]) begin
            dup[d][p] = 1'b1;
            if (q < p) lower_dup[d][p] = 1'b1;
          end
        end
      end
    end
  end

  // Lone requesters read their entry and schedule it to toggle.
  always_comb begin
    present_o = '0;
    bypass_o  = '0;
    ignore_o  = '0;
    toggle    = '0;
    for (int unsigned d = 0; d < N_DIMS; d++) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        bypass_o[d][p] = req_valid[d][p] & dup[d][p] & ~lower_dup[d][p];
        ignore_o[d][p] = req_valid[d][p] & lower_dup[d][p];
        for (int unsigned r = 0; r < N_REGS_PER_DIM; r++) begin
          if (req_valid[d][p] && !dup[d][p] && idx[d][p] == IDX_W'(r)) begin
            present_o[d][p] = entry_q[d][r];
            toggle[d][r]    = 1'b1;
          end
        end
      end
    end
  end

  // Next entry state and its population count; flush dominates.
  always_comb begin
    entry_d   = flush_i ? '0 : ((entry_q ^ toggle) & ~expire);
    pending_d = '0;
    for (int unsigned d = 0; d < N_DIMS; d++) begin
      for (int unsigned r = 0; r < N_REGS_PER_DIM; r++) begin
        pending_d[d] = pending_d[d] + CNT_W'(entry_d[d][r]);
      end
    end
  end

  // Entry storage and pending count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q   <= '0;
      pending_o <= '0;
    end else begin
      entry_q   <= entry_d;
      pending_o <= pending_d;
    end
  end

`ifdef FRACTAL_SYNC_ND_LOCAL_RF_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

  logic [N_DIMS-1:0][N_REGS_PER_DIM-1:0][AGE_W-1:0] age_q;
  logic [N_DIMS-1:0][N_REGS_PER_DIM-1:0][AGE_W-1:0] age_d;
  logic [N_DIMS-1:0]                                timeout_d;
  logic [N_DIMS-1:0][IDX_W-1:0]                     timeout_id_d;

  // An unmatched entry whose age hits TIMEOUT-1 expires at the next edge.
  always_comb begin
    expire       = '0;
    timeout_d    = '0;
    timeout_id_d = '0;
    for (int unsigned d = 0; d < N_DIMS; d++) begin
      for (int unsigned r = 0; r < N_REGS_PER_DIM; r++) begin
        expire[d][r] = entry_q[d][r] && (age_q[d][r] == AGE_W'(TIMEOUT - 1)) &&
                       !toggle[d][r] && !flush_i;
      end
      for (int r = int'(N_REGS_PER_DIM) - 1; r >= 0; r--) begin
        if (expire[d][r]) begin
          timeout_d[d]    = 1'b1;
          timeout_id_d[d] = IDX_W'(r);
        end
      end
    end
  end

  // Age counts edges while an entry stays set; restarts from zero when set.
  always_comb begin
    age_d = '0;
    for (int unsigned d = 0; d < N_DIMS; d++) begin
      for (int unsigned r = 0; r < N_REGS_PER_DIM; r++) begin
        if (entry_q[d][r] && entry_d[d][r]) age_d[d][r] = age_q[d][r] + AGE_W'(1);
      end
    end
  end

  // Age counters and the one-cycle expiry report.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q        <= '0;
      timeout_o    <= '0;
      timeout_id_o <= '0;
    end else begin
      age_q        <= age_d;
      timeout_o    <= timeout_d;
      timeout_id_o <= timeout_id_d;
    end
  end
`else
  assign expire       = '0;
  assign timeout_o    = '0;
  assign timeout_id_o = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_nd_local_rf.sv
// Randomised and directed bench for fractal_sync_nd_local_rf against a
// behavioural model of the barrier register file.
module tb_fractal_sync_nd_local_rf;

  localparam int ND = 2;
  localparam int NP = 3;
  localparam int NR = 4;
  localparam int IW = 4;
  localparam int TO = 8;
  localparam int PW = $clog2(NR + 1);
`ifdef FRACTAL_SYNC_ND_LOCAL_RF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [ND-1:0][NP-1:0][IW-1:0] id;
  logic [ND-1:0][NP-1:0]         chk_in;
  logic [ND-1:0][NP-1:0]         present, id_err, bypass, ignore;
  logic                          flush;
  logic [ND-1:0][PW-1:0]         pending;
  logic [ND-1:0]                 tmo;
  logic [ND-1:0][IW-2:0]         tmo_id;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit ent [ND][NR];
  int set_edge [ND][NR];
  bit to_q [ND];
  int toid_q [ND];
  int edge_n = 0;

  fractal_sync_nd_local_rf #(
    .N_DIMS(ND), .N_PORTS(NP), .N_REGS_PER_DIM(NR), .ID_WIDTH(IW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_i(id), .check_i(chk_in),
    .present_o(present), .id_err_o(id_err), .bypass_o(bypass), .ignore_o(ignore),
    .flush_i(flush), .pending_o(pending), .timeout_o(tmo), .timeout_id_o(tmo_id)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(int d, int p);
    return int'(id[d][p] >> 1);
  endfunction

  function automatic bit vreq(int d, int p);
    return chk_in[d][p] && (idx_of(d, p) < NR);
  endfunction

  function automatic int same_cnt(int d, int p);
    int c = 0;
    for (int q = 0; q < NP; q++)
      if (vreq(d, q) && idx_of(d, q) == idx_of(d, p)) c++;
    return c;
  endfunction

  function automatic int first_same(int d, int p);
    for (int q = 0; q < NP; q++)
      if (vreq(d, q) && idx_of(d, q) == idx_of(d, p)) return q;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      to_q[d] = 0;
      toid_q[d] = 0;
      for (int r = 0; r < NR; r++) ent[d][r] = 0;
    end
  endtask

  // Apply one clock edge of the barrier rules to the model.
  task automatic model_edge();
    bit hit [ND][NR];
    edge_n++;
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < NR; r++) hit[d][r] = 0;
      for (int p = 0; p < NP; p++)
        if (vreq(d, p) && same_cnt(d, p) == 1) hit[d][idx_of(d, p)] = 1;
      to_q[d] = 0;
      toid_q[d] = 0;
      for (int r = 0; r < NR; r++) begin
        if (flush) ent[d][r] = 0;
        else if (hit[d][r]) begin
          ent[d][r] = !ent[d][r];
          if (ent[d][r]) set_edge[d][r] = edge_n;
        end else if (TO_EN && ent[d][r] && (edge_n - set_edge[d][r] == TO)) begin
          ent[d][r] = 0;
          if (!to_q[d]) begin
            to_q[d] = 1;
            toid_q[d] = r;
          end
        end
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      int pend = 0;
      for (int p = 0; p < NP; p++) begin
        bit v = vreq(d, p);
        int n = v ? same_cnt(d, p) : 0;
        int f = v ? first_same(d, p) : -1;
        int e_pres = 0;
        if (n == 1) e_pres = int'(ent[d][idx_of(d, p)]);
        check($sformatf("id_err[%0d][%0d]", d, p), int'(id_err[d][p]), int'(chk_in[d][p] && !v));
        check($sformatf("bypass[%0d][%0d]", d, p), int'(bypass[d][p]), int'(n >= 2 && f == p));
        check($sformatf("ignore[%0d][%0d]", d, p), int'(ignore[d][p]), int'(n >= 2 && f != p));
        check($sformatf("present[%0d][%0d]", d, p), int'(present[d][p]), e_pres);
      end
      for (int r = 0; r < NR; r++) pend += int'(ent[d][r]);
      check($sformatf("pending[%0d]", d), int'(pending[d]), pend);
      check($sformatf("timeout[%0d]", d), int'(tmo[d]), int'(to_q[d]));
      check($sformatf("timeout_id[%0d]", d), int'(tmo_id[d]), toid_q[d]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic clear_in();
    chk_in = '0;
    id = '0;
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    model_reset();
    sample();
    check("reset_pending0", int'(pending[0]), 0);
    check("reset_timeout", int'(tmo), 0);
    advance();
    rst_n = 1'b1;

    // single arrival then match on d0 idx 3
    chk_in[0][0] = 1'b1; id[0][0] = 4'b0110;
    sample();
    check("arrive_present", int'(present[0][0]), 0);
    advance();
    clear_in();
    sample();
    check("arrive_pending0", int'(pending[0]), 1);
    check("arrive_pending1", int'(pending[1]), 0);
    advance();
    chk_in[0][1] = 1'b1; id[0][1] = 4'b0111;
    sample();
    check("match_present", int'(present[0][1]), 1);
    advance();
    clear_in();
    sample();
    check("match_pending0", int'(pending[0]), 0);
    advance();

    // three-way duplicate on d1 idx 2
    chk_in[1] = '1; id[1][0] = 4'b0100; id[1][1] = 4'b0101; id[1][2] = 4'b0100;
    sample();
    check("dup_bypass0", int'(bypass[1][0]), 1);
    check("dup_ignore1", int'(ignore[1][1]), 1);
    check("dup_ignore2", int'(ignore[1][2]), 1);
    check("dup_present", int'(present[1]), 0);
    advance();
    clear_in();
    sample();
    check("dup_pending1", int'(pending[1]), 0);
    advance();

    // out-of-range id
    chk_in[0][0] = 1'b1; id[0][0] = 4'b1000;
    sample();
    check("range_err", int'(id_err[0][0]), 1);
    check("range_bypass", int'(bypass[0][0] | ignore[0][0]), 0);
    #1 chk_in[0][0] = 1'b0;
    #1 check("range_err_nochk", int'(id_err[0][0]), 0);
    advance();
    sample();
    check("range_pending", int'(pending[0]), 0);
    advance();

    // flush overrides a same-cycle set
    chk_in[0] = '1; id[0][0] = 4'd0; id[0][1] = 4'd2; id[0][2] = 4'd4;
    advance();
    clear_in();
    sample();
    check("flush_pre_pending", int'(pending[0]), 3);
    advance();
    flush = 1'b1; chk_in[0][0] = 1'b1; id[0][0] = 4'b0110;
    sample();
    advance();
    clear_in();
    sample();
    check("flush_pending", int'(pending[0]), 0);
    advance();
    chk_in[0][0] = 1'b1; id[0][0] = 4'd0;
    sample();
    check("flush_present", int'(present[0][0]), 0);
    advance();
    clear_in(); flush = 1'b1;
    cyc();
    clear_in();

    // expiry of an unmatched entry at d0 idx 1
    chk_in[0][0] = 1'b1; id[0][0] = 4'b0010;
    cyc();
    clear_in();
    repeat (8) cyc();
    sample();
`ifdef FRACTAL_SYNC_ND_LOCAL_RF_TIMEOUT_EN
    check("to_pulse", int'(tmo[0]), 1);
    check("to_id", int'(tmo_id[0]), 1);
    check("to_pending", int'(pending[0]), 0);
`else
    check("to_pulse", int'(tmo[0]), 0);
    check("to_pending", int'(pending[0]), 1);
`endif
    advance();
    sample();
    check("to_pulse_end", int'(tmo[0]), 0);
    advance();
    flush = 1'b1;
    cyc();
    clear_in();

    // matching request in the expiry cycle wins
    chk_in[0][0] = 1'b1; id[0][0] = 4'b0010;
    cyc();
    clear_in();
    repeat (7) cyc();
    chk_in[0][1] = 1'b1; id[0][1] = 4'b0011;
    sample();
    check("to_match_present", int'(present[0][1]), 1);
    advance();
    clear_in();
    sample();
    check("to_match_nopulse", int'(tmo[0]), 0);
    check("to_match_pending", int'(pending[0]), 0);
    advance();

    // asynchronous reset with entries pending in both dimensions
    for (int d = 0; d < ND; d++) begin
      chk_in[d][0] = 1'b1; id[d][0] = 4'd0;
      chk_in[d][1] = 1'b1; id[d][1] = 4'd2;
    end
    advance();
    clear_in();
    sample();
    check("rst_pre_pending0", int'(pending[0]), 2);
    check("rst_pre_pending1", int'(pending[1]), 2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("rst_pending0", int'(pending[0]), 0);
    check("rst_pending1", int'(pending[1]), 0);
    #1 rst_n = 1'b1;
    advance();
    chk_in[0][0] = 1'b1; id[0][0] = 4'd0;
    sample();
    check("rst_present", int'(present[0][0]), 0);
    advance();
    clear_in();
    flush = 1'b1;
    cyc();
    clear_in();

    // randomised traffic with idle gaps so entries can age out
    begin
      int dens = 3;
      for (int c = 0; c < 2000; c++) begin
        if (c % 100 == 0) dens = $urandom_range(1, 5);
        if (c % 200 > 185) begin
          clear_in();
        end else begin
          for (int d = 0; d < ND; d++)
            for (int p = 0; p < NP; p++) begin
              chk_in[d][p] = ($urandom_range(0, 9) < dens);
              id[d][p] = IW'($urandom_range(0, 11));
            end
          flush = ($urandom_range(0, 79) == 0);
        end
        cyc();
      end
    end
    clear_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
